// File: rtl/clkdiv_pkg.sv
// Shared constants and ratio helpers for the programmable clock divider.
package clkdiv_pkg;

    localparam int unsigned CLKDIV_MIN_RATIO = 2;
    localparam int unsigned CLKDIV_DIV_W     = 8;

    // Ratios below the minimum cannot form a low and a high phase.
    function automatic int unsigned clkdiv_clamp(input int unsigned n);
        return (n < CLKDIV_MIN_RATIO) ? CLKDIV_MIN_RATIO : n;
    endfunction

    // Length of the low phase: ceil(n/2), computed without n+1 overflow.
    function automatic int unsigned clkdiv_ceil_half(input int unsigned n);
        return (n >> 1) + (n & 32'd1);
    endfunction

endpackage

// File: rtl/clkdiv_ratio_shadow.sv
// Holds a requested divide ratio and promotes it to the active ratio at a period wrap.
module clkdiv_ratio_shadow
    import clkdiv_pkg::*;
#(
    parameter int unsigned DIV_W     = CLKDIV_DIV_W,
    parameter int unsigned DIV_RESET = 10
) (
    input  logic             clock_in,
    input  logic             nReset,
    input  logic             div_load_i,
    input  logic [DIV_W-1:0] div_ratio_i,
    input  logic             wrap_i,
    output logic [DIV_W-1:0] ratio_active_o,
    output logic             div_pending_o,
    output logic             div_ack_o
);

    localparam logic [DIV_W-1:0] RESET_RATIO = DIV_W'(clkdiv_clamp(DIV_RESET));

    logic [DIV_W-1:0] req_c;
    logic [DIV_W-1:0] shadow_q, shadow_d;
    logic [DIV_W-1:0] active_q, active_d;
    logic             pending_q, pending_d;
    logic             ack_q, ack_d;

    assign req_c = DIV_W'(clkdiv_clamp(32'(div_ratio_i)));

    // A load on the wrap edge bypasses the shadow and applies at once.
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        ack_d     = 1'b0;
        if (div_load_i) begin
            shadow_d = req_c;
        end
        if (wrap_i) begin
            if (div_load_i) begin
                active_d  = req_c;
                pending_d = 1'b0;
                ack_d     = 1'b1;
            end else if (pending_q) begin
                active_d  = shadow_q;
                pending_d = 1'b0;
                ack_d     = 1'b1;
            end
        end else if (div_load_i) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clock_in or negedge nReset) begin
        if (!nReset) begin
            shadow_q  <= RESET_RATIO;
            active_q  <= RESET_RATIO;
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            ack_q     <= ack_d;
        end
    end

    assign ratio_active_o = active_q;
    assign div_pending_o  = pending_q;
    assign div_ack_o      = ack_q;

endmodule

// File: rtl/clock_divider_prog.sv
// Runtime-programmable clock divider: clock_out low ceil(N/2), high floor(N/2) cycles.
// Define CLKDIV_ODD_DUTY50_EN to stretch odd-ratio high phases by half a cycle (50% duty).
module clock_divider_prog
    import clkdiv_pkg::*;
#(
    parameter int unsigned DIV_W     = CLKDIV_DIV_W,
    parameter int unsigned DIV_RESET = 10
) (
    input  logic             clock_in,
    input  logic             nReset,
    input  logic             enable,
    input  logic [DIV_W-1:0] div_ratio,
    input  logic             div_load,
    output logic             div_ack,
    output logic             div_pending,
    output logic [DIV_W-1:0] ratio_active,
    output logic             clock_out,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] rise_cnt_c;
    logic [DIV_W-1:0] last_cnt_c;
    logic             wrap_c;
    logic             pos_q, pos_d;
    logic             tick_q, tick_d;

    assign rise_cnt_c = DIV_W'(clkdiv_ceil_half(32'(ratio_active))) - DIV_W'(1);
    assign last_cnt_c = ratio_active - DIV_W'(1);
    assign wrap_c     = enable && (cnt_q == last_cnt_c);

    clkdiv_ratio_shadow #(
        .DIV_W     (DIV_W),
        .DIV_RESET (DIV_RESET)
    ) u_shadow (
        .clock_in       (clock_in),
        .nReset         (nReset),
        .div_load_i     (div_load),
        .div_ratio_i    (div_ratio),
        .wrap_i         (wrap_c),
        .ratio_active_o (ratio_active),
        .div_pending_o  (div_pending),
        .div_ack_o      (div_ack)
    );

    // Rise point is always strictly before the wrap since the ratio is at least 2.
    always_comb begin
        cnt_d  = cnt_q;
        pos_d  = pos_q;
        tick_d = 1'b0;
        if (enable) begin
            if (wrap_c) begin
                cnt_d = '0;
                pos_d = 1'b0;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
            if (cnt_q == rise_cnt_c) begin
                pos_d  = 1'b1;
                tick_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock_in or negedge nReset) begin
        if (!nReset) begin
            cnt_q  <= '0;
            pos_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pos_q  <= pos_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

`ifdef CLKDIV_ODD_DUTY50_EN
    logic neg_q;

    // Half-cycle delayed copy widens the high phase for odd ratios.
    always_ff @(negedge clock_in or negedge nReset) begin
        if (!nReset) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= pos_q;
        end
    end

    assign clock_out = ratio_active[0] ? (pos_q | neg_q) : pos_q;
`else
    assign clock_out = pos_q;
`endif

endmodule

// File: tb/tb_clock_divider_prog.sv
// Self-checking bench for clock_divider_prog (default build, odd-duty feature off).
module tb_clock_divider_prog;

    localparam int unsigned DW = 8;

    logic          clock_in = 1'b0;
    logic          nReset;
    logic          enable;
    logic          div_load;
    logic [DW-1:0] div_ratio;
    logic          div_ack;
    logic          div_pending;
    logic [DW-1:0] ratio_active;
    logic          clock_out;
    logic          tick;

    clock_divider_prog #(.DIV_W(DW), .DIV_RESET(10)) dut (
        .clock_in     (clock_in),
        .nReset       (nReset),
        .enable       (enable),
        .div_ratio    (div_ratio),
        .div_load     (div_load),
        .div_ack      (div_ack),
        .div_pending  (div_pending),
        .ratio_active (ratio_active),
        .clock_out    (clock_out),
        .tick         (tick)
    );

    always #5 clock_in = ~clock_in;

    int passed = 0;
    int total  = 0;

    // Reference model: position within the period and the ratio bookkeeping.
    int m_n, m_cnt, m_shadow;
    bit m_pend, e_tick, e_ack;
    int tick_seen = 0, hi_seen = 0, ack_seen = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int clampf(input int r);
        return (r < 2) ? 2 : r;
    endfunction

    function automatic int halfup(input int n);
        return (n + 1) / 2;
    endfunction

    task automatic model_reset();
        m_n = 10; m_cnt = 0; m_shadow = 10; m_pend = 0; e_tick = 0; e_ack = 0;
    endtask

    task automatic model_step();
        bit wrap;
        e_tick = 0;
        e_ack  = 0;
        wrap   = enable && (m_cnt == m_n - 1);
        if (enable) begin
            if (wrap) m_cnt = 0;
            else begin
                m_cnt++;
                e_tick = (m_cnt == halfup(m_n));
            end
        end
        if (wrap) begin
            if (div_load) begin
                m_n = clampf(int'(div_ratio)); m_shadow = m_n; m_pend = 0; e_ack = 1;
            end else if (m_pend) begin
                m_n = m_shadow; m_pend = 0; e_ack = 1;
            end
        end else if (div_load) begin
            m_shadow = clampf(int'(div_ratio)); m_pend = 1;
        end
    endtask

    task automatic monitor();
        forever begin
            @(posedge clock_in);
            if (!nReset) model_reset();
            else model_step();
            #1;
            check("clock_out", int'(clock_out), (m_cnt >= halfup(m_n)) ? 1 : 0);
            check("tick", int'(tick), int'(e_tick));
            check("div_ack", int'(div_ack), int'(e_ack));
            check("div_pending", int'(div_pending), int'(m_pend));
            check("ratio_active", int'(ratio_active), m_n);
            tick_seen += int'(tick);
            hi_seen   += int'(clock_out);
            ack_seen  += int'(div_ack);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock_in);
    endtask

    task automatic load_pulse(input int r);
        div_ratio = DW'(r);
        div_load  = 1'b1;
        @(negedge clock_in);
        div_load  = 1'b0;
    endtask

    task automatic wait_ack(input int max_cycles);
        bit found = 0;
        for (int i = 0; i < max_cycles; i++) begin
            if (div_ack) begin
                found = 1;
                break;
            end
            @(negedge clock_in);
        end
        check("ack_within_budget", int'(found), 1);
    endtask

    // Count ticks, high cycles and acks over a window with literal expectations.
    task automatic measure(input int n, input int exp_tick, input int exp_hi, input int exp_ack);
        int t0, h0, a0;
        t0 = tick_seen; h0 = hi_seen; a0 = ack_seen;
        step(n);
        check("window_ticks", tick_seen - t0, exp_tick);
        check("window_high", hi_seen - h0, exp_hi);
        check("window_acks", ack_seen - a0, exp_ack);
    endtask

    initial begin
        int a0, h0, t0;
        nReset = 1'b0; enable = 1'b0; div_load = 1'b0; div_ratio = '0;
        model_reset();
        fork
            monitor();
        join_none
        step(3);
        check("reset_ratio", int'(ratio_active), 10);
        check("reset_clock_out", int'(clock_out), 0);
        check("reset_pending", int'(div_pending), 0);
        nReset = 1'b1;
        enable = 1'b1;

        // Default 1/10: 5 low / 5 high, one tick per period.
        measure(20, 2, 10, 0);

        // Load 4 mid-period; applied only at the end of the 10-cycle period.
        step(3);
        load_pulse(4);
        check("pending_after_load4", int'(div_pending), 1);
        wait_ack(20);
        check("ratio_4", int'(ratio_active), 4);
        measure(16, 4, 8, 0);

        // Odd ratio 7: 4 low / 3 high.
        load_pulse(7);
        wait_ack(20);
        measure(14, 2, 6, 0);

        // Ratios 0 and 1 clamp to 2; same-ratio reload still acknowledged.
        load_pulse(0);
        wait_ack(20);
        check("ratio_clamp0", int'(ratio_active), 2);
        measure(8, 4, 4, 0);
        load_pulse(1);
        wait_ack(20);
        check("ratio_clamp1", int'(ratio_active), 2);

        // Two loads within one period: latest wins, single ack.
        load_pulse(10);
        wait_ack(20);
        a0 = ack_seen;
        step(1);
        load_pulse(6);
        load_pulse(12);
        step(12);
        check("single_ack", ack_seen - a0, 1);
        check("ratio_12", int'(ratio_active), 12);

        // Load on the wrap edge applies immediately without pending.
        step(6);
        load_pulse(4);
        check("wrap_load_ack", int'(div_ack), 1);
        check("wrap_load_pending", int'(div_pending), 0);
        check("wrap_load_ratio", int'(ratio_active), 4);

        // Enable low for 3 cycles in the high phase stretches it by 3.
        step(2);
        h0 = hi_seen; t0 = tick_seen;
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock_in);
            check("held_high", int'(clock_out), 1);
        end
        enable = 1'b1;
        step(2);
        check("stretched_high", hi_seen - h0, 4);
        check("stretched_ticks", tick_seen - t0, 0);
        measure(4, 1, 2, 0);

        // Reset mid-period discards a pending load.
        step(1);
        load_pulse(8);
        check("pending_before_reset", int'(div_pending), 1);
        step(1);
        nReset = 1'b0;
        #1;
        check("rst_pending", int'(div_pending), 0);
        check("rst_ratio", int'(ratio_active), 10);
        check("rst_clock_out", int'(clock_out), 0);
        check("rst_tick", int'(tick), 0);
        @(negedge clock_in);
        nReset = 1'b1;
        a0 = ack_seen;
        step(12);
        check("no_stale_ack", ack_seen - a0, 0);
        check("ratio_after_reset", int'(ratio_active), 10);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
